// File: rtl/reg_req_encoder.sv
// Serializes one-hot/multi-hot register requests into register numbers, one per
// valid/ready handshake, using round-robin or fixed-priority arbitration.
module reg_req_encoder #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned REG_W    = 3,
    parameter bit          RR_EN    = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REGS-1:0] req_in,
    input  logic                req_valid,
    output logic [REG_W-1:0]    reg_num,
    output logic                num_valid,
    input  logic                num_ready,
    output logic [NUM_REGS-1:0] pending_out
);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    state_e              state_q, state_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] pend_by_reg, grant_mask, capture;
    logic [REG_W-1:0]    reg_num_q, reg_num_d;
    logic [REG_W-1:0]    ptr_q, ptr_d;
    logic [REG_W-1:0]    base, idx, sel;
    logic                found, grant;

    // Vector bit order is reversed relative to reg number: reg k lives in bit NUM_REGS-1-k.
    always_comb begin
        pend_by_reg = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            pend_by_reg[k] = pending_q[NUM_REGS-1-k];
        end
    end

    always_comb begin
        base  = RR_EN ? ptr_q : '0;
        idx   = '0;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            idx = base + REG_W'(i);
            if (!found && pend_by_reg[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        reg_num_d = reg_num_q;
        grant     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant   = 1'b1;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (num_ready) begin
                    if (found) begin
                        grant = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (grant) begin
            reg_num_d = sel;
        end
    end

    // Capture is ORed in after the grant clear, so a same-edge re-request survives.
    always_comb begin
        grant_mask = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            grant_mask[NUM_REGS-1-k] = grant && (sel == REG_W'(k));
        end
        capture   = req_valid ? req_in : '0;
        pending_d = (pending_q & ~grant_mask) | capture;
        ptr_d     = (RR_EN && grant) ? sel + 1'b1 : ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pending_q <= '0;
            reg_num_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            reg_num_q <= reg_num_d;
            ptr_q     <= ptr_d;
        end
    end

    assign reg_num     = reg_num_q;
    assign num_valid   = (state_q == StPresent);
    assign pending_out = pending_q;

endmodule
